// File: rtl/me_block_scheduler.sv
// Frame-level sequencer for the full-search ME core: one req/ack search per block, result streamed on valid/ready.
// Optional best-block tracking is enabled by defining ME_SCHED_BEST_TRACK_EN.
module me_block_scheduler #(
    parameter int NUM_BLOCKS     = 16,
    parameter int SAD_WIDTH      = 16,
    parameter int CNT_WIDTH      = 12,
    parameter int TIMEOUT_CYCLES = 65536,
    localparam int BLK_WIDTH     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [BLK_WIDTH-1:0] blk_idx,
    output logic                 me_req,
    input  logic                 me_ack,
    input  logic [SAD_WIDTH-1:0] me_min_sad,
    input  logic [CNT_WIDTH-1:0] me_min_mvec,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SAD_WIDTH-1:0] res_sad,
    output logic [CNT_WIDTH-1:0] res_mvec,
    output logic [BLK_WIDTH-1:0] res_idx,
`ifdef ME_SCHED_BEST_TRACK_EN
    output logic [SAD_WIDTH-1:0] best_sad,
    output logic [CNT_WIDTH-1:0] best_mvec,
    output logic [BLK_WIDTH-1:0] best_idx,
`endif
    output logic                 res_last
);
    localparam int TMR_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [BLK_WIDTH-1:0] LAST_IDX = BLK_WIDTH'(NUM_BLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_ACK, S_ACK_LOW, S_PUSH, S_DONE
    } state_t;

    state_t                 r_state,       w_state_next;
    logic                   r_busy,        w_busy_next;
    logic                   r_done,        w_done_next;
    logic                   r_timeout_err, w_timeout_err_next;
    logic [BLK_WIDTH-1:0]   r_blk_idx,     w_blk_idx_next;
    logic                   r_me_req,      w_me_req_next;
    logic                   r_res_valid,   w_res_valid_next;
    logic [SAD_WIDTH-1:0]   r_res_sad,     w_res_sad_next;
    logic [CNT_WIDTH-1:0]   r_res_mvec,    w_res_mvec_next;
    logic [BLK_WIDTH-1:0]   r_res_idx,     w_res_idx_next;
    logic                   r_res_last,    w_res_last_next;
    logic [TMR_WIDTH-1:0]   r_cnt,         w_cnt_next;
`ifdef ME_SCHED_BEST_TRACK_EN
    logic [SAD_WIDTH-1:0]   r_best_sad,    w_best_sad_next;
    logic [CNT_WIDTH-1:0]   r_best_mvec,   w_best_mvec_next;
    logic [BLK_WIDTH-1:0]   r_best_idx,    w_best_idx_next;
`endif

    always_comb begin
        w_state_next       = r_state;
        w_busy_next        = r_busy;
        w_done_next        = 1'b0;
        w_timeout_err_next = r_timeout_err;
        w_blk_idx_next     = r_blk_idx;
        w_me_req_next      = r_me_req;
        w_res_valid_next   = r_res_valid;
        w_res_sad_next     = r_res_sad;
        w_res_mvec_next    = r_res_mvec;
        w_res_idx_next     = r_res_idx;
        w_res_last_next    = r_res_last;
        w_cnt_next         = r_cnt;
`ifdef ME_SCHED_BEST_TRACK_EN
        w_best_sad_next    = r_best_sad;
        w_best_mvec_next   = r_best_mvec;
        w_best_idx_next    = r_best_idx;
`endif
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_next       = S_REQ;
                    w_blk_idx_next     = '0;
                    w_timeout_err_next = 1'b0;
                    w_busy_next        = 1'b1;
`ifdef ME_SCHED_BEST_TRACK_EN
                    w_best_sad_next    = '1;
                    w_best_mvec_next   = '0;
                    w_best_idx_next    = '0;
`endif
                end
            end
            S_REQ: begin
                w_me_req_next = 1'b1;
                w_cnt_next    = '0;
                w_state_next  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // An ack on the final allowed cycle still wins over the timeout
                if (me_ack) begin
                    w_res_sad_next  = me_min_sad;
                    w_res_mvec_next = me_min_mvec;
                    w_me_req_next   = 1'b0;
                    w_state_next    = S_ACK_LOW;
`ifdef ME_SCHED_BEST_TRACK_EN
                    if (me_min_sad < r_best_sad) begin
                        w_best_sad_next  = me_min_sad;
                        w_best_mvec_next = me_min_mvec;
                        w_best_idx_next  = r_blk_idx;
                    end
`endif
                end else if (r_cnt == TMR_LAST) begin
                    w_res_sad_next     = '1;
                    w_res_mvec_next    = '0;
                    w_me_req_next      = 1'b0;
                    w_timeout_err_next = 1'b1;
                    w_state_next       = S_ACK_LOW;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_ACK_LOW: begin
                if (!me_ack) begin
                    w_res_valid_next = 1'b1;
                    w_res_idx_next   = r_blk_idx;
                    w_res_last_next  = (r_blk_idx == LAST_IDX);
                    w_state_next     = S_PUSH;
                end
            end
            S_PUSH: begin
                if (res_ready) begin
                    w_res_valid_next = 1'b0;
                    if (r_blk_idx == LAST_IDX) begin
                        w_done_next  = 1'b1;
                        w_busy_next  = 1'b0;
                        w_state_next = S_DONE;
                    end else begin
                        w_blk_idx_next = r_blk_idx + 1'b1;
                        w_state_next   = S_REQ;
                    end
                end
            end
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase

        // Abort overrides whatever the handshakes decided this cycle
        if (abort && r_state != S_IDLE) begin
            w_state_next     = S_IDLE;
            w_me_req_next    = 1'b0;
            w_res_valid_next = 1'b0;
            w_busy_next      = 1'b0;
            w_done_next      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_blk_idx     <= '0;
            r_me_req      <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_sad     <= '0;
            r_res_mvec    <= '0;
            r_res_idx     <= '0;
            r_res_last    <= 1'b0;
            r_cnt         <= '0;
`ifdef ME_SCHED_BEST_TRACK_EN
            r_best_sad    <= '0;
            r_best_mvec   <= '0;
            r_best_idx    <= '0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_timeout_err <= w_timeout_err_next;
            r_blk_idx     <= w_blk_idx_next;
            r_me_req      <= w_me_req_next;
            r_res_valid   <= w_res_valid_next;
            r_res_sad     <= w_res_sad_next;
            r_res_mvec    <= w_res_mvec_next;
            r_res_idx     <= w_res_idx_next;
            r_res_last    <= w_res_last_next;
            r_cnt         <= w_cnt_next;
`ifdef ME_SCHED_BEST_TRACK_EN
            r_best_sad    <= w_best_sad_next;
            r_best_mvec   <= w_best_mvec_next;
            r_best_idx    <= w_best_idx_next;
`endif
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign blk_idx     = r_blk_idx;
    assign me_req      = r_me_req;
    assign res_valid   = r_res_valid;
    assign res_sad     = r_res_sad;
    assign res_mvec    = r_res_mvec;
    assign res_idx     = r_res_idx;
    assign res_last    = r_res_last;
`ifdef ME_SCHED_BEST_TRACK_EN
    assign best_sad    = r_best_sad;
    assign best_mvec   = r_best_mvec;
    assign best_idx    = r_best_idx;
`endif
endmodule
